// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared FSM states, key codes and key lookup for the keypad scanner
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Rows 0-2 hold digits 1-9 in reading order; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  function automatic logic [3:0] row_mask(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - counts consecutive cycles of a condition; done on the N-th one
module keypad_debounce #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_ok,
  output logic o_done
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || !i_ok) begin
      r_cnt <= '0;
    end else if (r_cnt != CW'(N - 1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = i_ok && !i_clr && (r_cnt == CW'(N - 1));

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad scanner with debounce, digit count and '*'/'#' events
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_in,
  output logic [3:0] row_drv,
  output logic [3:0] number,
  output logic       digit_valid,
  output logic [2:0] count,
  output logic       clear_pulse,
  output logic       enter_pulse
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [2:0]    r_sync1, r_sync2;
  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_div;
  logic [1:0]    r_row, r_col;
  logic [3:0]    r_row_drv, r_number;
  logic [2:0]    r_count;
  logic          r_digit_valid, r_clear_pulse, r_enter_pulse;

  logic [2:0] w_col, w_col_exp;
  logic       w_col_one, w_slot_end;
  logic [1:0] w_col_idx;
  logic       w_deb_ok, w_deb_clr, w_deb_done;
  logic [3:0] w_code;

  assign w_col      = r_sync2;
  assign w_col_one  = (w_col == 3'b110) || (w_col == 3'b101) || (w_col == 3'b011);
  assign w_col_idx  = (w_col == 3'b110) ? 2'd0 : (w_col == 3'b101) ? 2'd1 : 2'd2;
  assign w_slot_end = (r_div == DW'(SCAN_DIV - 1));
  assign w_col_exp  = ~(3'b001 << r_col);
  assign w_code     = key_code(r_row, r_col);

  // One counter serves both phases: press stability while debouncing, all-high while releasing.
  assign w_deb_ok  = (r_state == ST_DEBOUNCE) ? (w_col == w_col_exp) : (w_col == 3'b111);
  assign w_deb_clr = (r_state != ST_DEBOUNCE) && (r_state != ST_RELEASE);

  keypad_debounce #(.N(DEB_CYCLES)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_deb_clr),
    .i_ok   (w_deb_ok),
    .o_done (w_deb_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_SCAN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SCAN:     if (w_slot_end && w_col_one) w_state_nxt = ST_DEBOUNCE;
      ST_DEBOUNCE: if (w_deb_done) w_state_nxt = ST_EMIT;
                   else if (!w_deb_ok) w_state_nxt = ST_SCAN;
      ST_EMIT:     w_state_nxt = ST_RELEASE;
      ST_RELEASE:  if (w_deb_done) w_state_nxt = ST_SCAN;
      default:     w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1       <= 3'b111;
      r_sync2       <= 3'b111;
      r_div         <= '0;
      r_row         <= 2'd0;
      r_col         <= 2'd0;
      r_row_drv     <= 4'b1110;
      r_number      <= 4'd0;
      r_count       <= 3'd0;
      r_digit_valid <= 1'b0;
      r_clear_pulse <= 1'b0;
      r_enter_pulse <= 1'b0;
    end else begin
      r_sync1       <= col_in;
      r_sync2       <= r_sync1;
      r_digit_valid <= 1'b0;
      r_clear_pulse <= 1'b0;
      r_enter_pulse <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (w_slot_end) begin
            r_div <= '0;
            if (w_col_one) begin
              r_col <= w_col_idx;
            end else begin
              r_row     <= r_row + 2'd1;
              r_row_drv <= row_mask(r_row + 2'd1);
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          // Pulses are set here so they are visible during the single EMIT cycle.
          if (w_deb_done) begin
            if (w_code == KEY_STAR) begin
              r_clear_pulse <= 1'b1;
              r_count       <= 3'd0;
            end else if (w_code == KEY_HASH) begin
              r_enter_pulse <= 1'b1;
            end else begin
              r_digit_valid <= 1'b1;
              r_number      <= w_code;
              if (r_count != 3'd7) r_count <= r_count + 3'd1;
            end
          end else if (!w_deb_ok) begin
            r_div     <= '0;
            r_row     <= r_row + 2'd1;
            r_row_drv <= row_mask(r_row + 2'd1);
          end
        end
        ST_EMIT: ;
        ST_RELEASE: begin
          if (w_deb_done) begin
            r_div     <= '0;
            r_row     <= 2'd0;
            r_row_drv <= 4'b1110;
          end
        end
        default: begin
          r_div     <= '0;
          r_row     <= 2'd0;
          r_row_drv <= 4'b1110;
        end
      endcase
    end
  end

  assign row_drv     = r_row_drv;
  assign number      = r_number;
  assign count       = r_count;
  assign digit_valid = r_digit_valid;
  assign clear_pulse = r_clear_pulse;
  assign enter_pulse = r_enter_pulse;

endmodule
